// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO slice.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W = 128;
    localparam int unsigned FIFO_DEPTH  = 16;

    typedef logic [FIFO_DATA_W-1:0] fifo_data_t;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned fifo_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Simple dual-port register array with a registered, reset-to-zero read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read data, held when no read is issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, acceptance, status flags and error pulses.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = FIFO_DATA_W,
    parameter int unsigned DEPTH     = FIFO_DEPTH,
    parameter int unsigned AF_MARGIN = 2,
    parameter int unsigned AE_MARGIN = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_wren,
    input  logic [DATA_W-1:0]             i_wrdata,
    input  logic                          i_rden,
    output logic [DATA_W-1:0]             o_rddata,
    output logic                          o_full,
    output logic                          o_alm_full,
    output logic                          o_empty,
    output logic                          o_alm_empty,
    output logic [fifo_cnt_w(DEPTH)-1:0]  o_count,
    output logic                          o_overflow,
    output logic                          o_underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = fifo_cnt_w(DEPTH);

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_MARGIN);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          rd_acc;
    logic          wr_acc;

    // Acceptance from registered state; a read frees the slot a full-FIFO write needs.
    always_comb begin
        rd_acc = i_rden && !o_empty;
        wr_acc = i_wren && (!o_full || rd_acc);
    end

    // Status flags are pure compares on the registered count.
    always_comb begin
        o_full      = (count == CNT_FULL);
        o_alm_full  = (count >= AF_LVL);
        o_empty     = (count == '0);
        o_alm_empty = (count <= AE_LVL);
        o_count     = count;
    end

    // Pointer, occupancy and error-pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            o_overflow  <= i_wren && !wr_acc;
            o_underflow <= i_rden && !rd_acc;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk    (clk),
        .reset  (reset),
        .we     (wr_acc),
        .waddr  (wr_ptr),
        .wdata  (i_wrdata),
        .re     (rd_acc),
        .raddr  (rd_ptr),
        .rdata  (o_rddata)
    );

endmodule : sync_fifo
